// File: rtl/demux18_sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel word demux.
// Optional parity slot is enabled with DEMUX18_SIPO_PARITY_EN.
package demux18_sipo_pkg;

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;

  // Index of the final slot in a word: the parity slot sits after the data bits.
  function automatic int slot_limit(input int width);
`ifdef DEMUX18_SIPO_PARITY_EN
    return width;
`else
    return width - 1;
`endif
  endfunction

endpackage

// File: rtl/demux18_slot_cnt.sv
// Slot counter acting as the demux select: increment, sync-clear, wrap at LIMIT.
module demux18_slot_cnt #(
  parameter int CW    = 3,
  parameter int LIMIT = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(LIMIT));

  // A clear coinciding with an accept makes that bit slot 0, so the next is slot 1.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= inc ? CW'(1) : '0;
    else if (inc) cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/demux18_sipo.sv
// Serial bit stream to WIDTH-bit words, LSB first, with a one-entry output register.
// Define DEMUX18_SIPO_PARITY_EN to add an even-parity slot and the out_perr output.
module demux18_sipo
  import demux18_sipo_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DEMUX18_SIPO_PARITY_EN
  ,
  output logic             out_perr
`endif
);

`ifdef DEMUX18_SIPO_PARITY_EN
  localparam int CW = SEL_W + 1;
`else
  localparam int CW = SEL_W;
`endif
  localparam int LIMIT = slot_limit(WIDTH);
  localparam int SW    = LIMIT + 1;

  state_t          state, state_nxt;
  logic [SW-1:0]   shadow, word_nxt;
  logic [CW-1:0]   slot, eff_slot;
  logic            last, sync_c, accept, complete, out_free;

  assign in_ready = (state != FULL);
  assign accept   = in_valid && in_ready;
  assign sync_c   = in_sync && (state == COLLECT);
  assign eff_slot = sync_c ? '0 : slot;
  assign complete = accept && last && !sync_c;
  assign out_free = !out_valid || out_ready;

  demux18_slot_cnt #(.CW(CW), .LIMIT(LIMIT)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (sync_c),
    .cnt   (slot),
    .last  (last)
  );

  // Word as it stands after this cycle's bit; sync drops the partial word first.
  always_comb begin
    word_nxt = sync_c ? '0 : shadow;
    if (accept) word_nxt[eff_slot] = in_bit;
  end

  // Shadow is frozen in FULL: it holds the parked word until the output frees.
  always_ff @(posedge clk) begin
    if (!rst_n)                shadow <= '0;
    else if (state == COLLECT) shadow <= word_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (complete && !out_free) state_nxt = FULL;
      FULL:    if (out_ready)             state_nxt = COLLECT;
      default:                            state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (state == FULL) begin
      if (out_ready) out_word <= shadow[WIDTH-1:0];
    end else if (complete && out_free) begin
      out_word  <= word_nxt[WIDTH-1:0];
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DEMUX18_SIPO_PARITY_EN
  // Parity travels with out_word through the same load conditions.
  always_ff @(posedge clk) begin
    if (!rst_n)                        out_perr <= 1'b0;
    else if (state == FULL) begin
      if (out_ready)                   out_perr <= ^shadow;
    end else if (complete && out_free) out_perr <= ^word_nxt;
  end
`endif

endmodule

// File: tb/tb_demux18_sipo.sv
// Directed self-checking bench for demux18_sipo (optionally with DEMUX18_SIPO_PARITY_EN).
module tb_demux18_sipo;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_bit, in_valid, in_sync, in_ready;
  logic [W-1:0] out_word;
  logic         out_valid, out_ready;
`ifdef DEMUX18_SIPO_PARITY_EN
  logic         out_perr;
`endif

  int errors = 0;
  int checks = 0;

  demux18_sipo #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX18_SIPO_PARITY_EN
    ,
    .out_perr  (out_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Everything but the word's final stream bit (the parity bit when enabled).
  task automatic send_head(input logic [W-1:0] w);
`ifdef DEMUX18_SIPO_PARITY_EN
    for (int i = 0; i < W; i++) send_bit(w[i]);
`else
    for (int i = 0; i < W-1; i++) send_bit(w[i]);
`endif
  endtask

  task automatic send_tail(input logic [W-1:0] w);
`ifdef DEMUX18_SIPO_PARITY_EN
    send_bit(^w);
`else
    send_bit(w[W-1]);
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_head(w);
    send_tail(w);
  endtask

  initial begin
    logic [W-1:0] w;
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_sync = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_word",  out_word,  8'h00);
    chk("rst_ready", in_ready,  1'b1);
    rst_n = 1'b1;

    // 1,0,1,1,0,0,1,0 LSB first -> 8'h4D, valid one cycle after the last bit
    send_head(8'h4D);
    chk("w1_early_valid", out_valid, 1'b0);
    send_tail(8'h4D);
    chk("w1_valid", out_valid, 1'b1);
    chk("w1_word",  out_word,  8'h4D);
    idle(1);
    chk("w1_drain", out_valid, 1'b0);

    // Back-to-back words with a stalled consumer
    out_ready = 1'b0;
    send_word(8'hA5);
    chk("b2b_first_valid", out_valid, 1'b1);
    chk("b2b_first_word",  out_word,  8'hA5);
    send_head(8'h3C);
    chk("b2b_hold_word",   out_word,  8'hA5);
    chk("b2b_mid_ready",   in_ready,  1'b1);
    send_tail(8'h3C);
    chk("b2b_full_ready",  in_ready,  1'b0);
    chk("b2b_full_valid",  out_valid, 1'b1);
    chk("b2b_full_word",   out_word,  8'hA5);
    send_bit(1'b1);  // offered while FULL: must be refused
    chk("b2b_stall_word",  out_word,  8'hA5);
    out_ready = 1'b1;
    idle(1);
    chk("b2b_second_word",  out_word,  8'h3C);
    chk("b2b_second_valid", out_valid, 1'b1);
    chk("b2b_ready_again",  in_ready,  1'b1);
    idle(1);
    chk("b2b_drain", out_valid, 1'b0);

    // Sync realigns: three stray bits, then sync+bit becomes slot 0 of 8'h85
    w = 8'h85;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    in_sync = 1'b1;
    send_bit(w[0]);
    in_sync = 1'b0;
    for (int i = 1; i < W-1; i++) begin
      send_bit(w[i]);
      chk("sync_mid_valid", out_valid, 1'b0);
    end
`ifdef DEMUX18_SIPO_PARITY_EN
    send_bit(w[W-1]);
    chk("sync_mid_valid", out_valid, 1'b0);
    send_bit(^w);
`else
    send_bit(w[W-1]);
`endif
    chk("sync_valid", out_valid, 1'b1);
    chk("sync_word",  out_word,  8'h85);
    idle(1);

    // Reset mid-word with a held output word
    out_ready = 1'b0;
    send_word(8'hFF);
    chk("rst2_pre_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_word",  out_word,  8'h00);
    chk("rst2_ready", in_ready,  1'b1);
    out_ready = 1'b1;
    send_head(8'h5A);
    chk("rst2_early_valid", out_valid, 1'b0);
    send_tail(8'h5A);
    chk("rst2_word_after", out_word, 8'h5A);
    idle(1);

    // in_valid gaps (with in_bit=0 during gaps) across 8'hFF
    for (int i = 0; i < W; i++) begin
      send_bit(1'b1);
      in_bit = 1'b0;
      idle(1);
      if (i < W-1) chk("gap_mid_valid", out_valid, 1'b0);
    end
`ifdef DEMUX18_SIPO_PARITY_EN
    chk("gap_parity_wait", out_valid, 1'b0);
    send_bit(1'b0);
    chk("gap_word",  out_word,  8'hFF);
    chk("gap_perr",  out_perr,  1'b0);
`else
    chk("gap_word_valid", out_valid, 1'b0);
    chk("gap_word",       out_word,  8'hFF);
`endif
    idle(1);

`ifdef DEMUX18_SIPO_PARITY_EN
    // 8'h07 has odd weight: parity 0 flags an error, parity 1 is clean
    send_head(8'h07);
    send_bit(1'b0);
    chk("par_bad_word", out_word, 8'h07);
    chk("par_bad_perr", out_perr, 1'b1);
    idle(1);
    send_head(8'h07);
    send_bit(1'b1);
    chk("par_ok_word", out_word, 8'h07);
    chk("par_ok_perr", out_perr, 1'b0);
    idle(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
